branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
//
// PURPOSE
// Execute-stage branch resolution. It compares the actual outcome of each resolved branch
// with the prediction that fetch carried down the pipeline, and raises a registered
// mispredict/redirect to fetch. It also drives the registered update bus that trains the
// BHT/BTB predictor. After a redirect, a squash FSM ignores wrong-path branches until the
// flush has drained. Saturating performance counters track branches and mispredicts.
//
// PARAMETERS
// ADDR_WIDTH   64  PC / target address width.
// FLUSH_DEPTH  2   Non-stalled exec cycles ignored after a mispredict (wrong-path window); >=1.
// COUNT_WIDTH  32  Width of each performance counter.
//
// PORTS
// i_clk             in   1           Clock; all state updates on rising edge.
// i_arst            in   1           Reset: synchronous, active-low.
// i_stall_exec      in   1           Execute stage stalled; no evaluation this cycle.
// i_valid_exec      in   1           Execute stage holds a valid instruction.
// i_branch_instr    in   1           Instruction is a branch or jump.
// i_branch_taken    in   1           Actual resolved direction.
// i_pc_exec         in   ADDR_WIDTH  PC of the resolving instruction.
// i_pc_target_exec  in   ADDR_WIDTH  Actual taken target.
// i_pred_taken      in   1           Predicted direction carried from fetch.
// i_pred_target     in   ADDR_WIDTH  Predicted target carried from fetch.
// i_pred_way        in   2           BTB way reported at fetch for this PC.
// o_mispredict      out  1           One-cycle flush/redirect pulse.
// o_pc_redirect     out  ADDR_WIDTH  Correct next PC; valid while o_mispredict is high.
// o_bpu_update      out  1           One-cycle predictor-update strobe.
// o_bpu_taken       out  1           Actual direction sent to the predictor.
// o_bpu_pc          out  ADDR_WIDTH  Branch PC sent to the predictor.
// o_bpu_target      out  ADDR_WIDTH  Actual target sent to the predictor.
// o_bpu_way         out  2           Way to write, echoed from i_pred_way.
// o_branch_count    out  COUNT_WIDTH Branches resolved (saturating).
// o_mispred_count   out  COUNT_WIDTH Mispredicts (saturating).
//
// BEHAVIOUR
// - Reset (i_arst == 0 at a clock edge):
//   - All outputs and counters go to 0; FSM goes to RUN; squash counter goes to 0.
//   - Reset takes effect from any state, including mid-SQUASH.
// - Evaluation condition:
//   - eval = i_valid_exec & i_branch_instr & ~i_stall_exec & (state == RUN).
// - Mispredict condition:
//   - mis = eval & ((i_pred_taken != i_branch_taken)
//                   | (i_pred_taken & i_branch_taken & (i_pred_target != i_pc_target_exec))).
// - Redirect address:
//   - Equals i_pc_target_exec if i_branch_taken, else i_pc_exec + 4.
//   - Computed modulo 2^ADDR_WIDTH; wraps with no error.
// - Latency: all outputs are registered, 1 cycle after the evaluated edge.
//   - o_bpu_update = eval; o_bpu_* fields latch the inputs on eval and hold otherwise.
//   - o_mispredict = mis; o_pc_redirect latches on mis and holds otherwise.
//   - Both strobes are single-cycle pulses, with no handshake; downstream must accept them.
// - Correctly predicted branches still produce o_bpu_update, to train the BHT.
//   - o_mispredict stays 0 for them.
// - FSM states:
//   - RUN: evaluate normally. On mis, load the squash counter with FLUSH_DEPTH and go to SQUASH.
//   - SQUASH: no evaluation.
//     - The counter decrements on each ~i_stall_exec cycle and holds while stalled.
//     - Return to RUN in the cycle after the counter reaches 0.
//     - Valid branches seen in SQUASH produce no update, no mispredict and no count.
// - Counters:
//   - o_branch_count increments on eval; o_mispred_count increments on mis.
//   - Each saturates at all-ones and never wraps.
// - i_stall_exec high:
//   - No evaluation takes place; strobes are 0 on the next cycle.
//   - A pending registered pulse already in flight is not extended.
// - A non-branch valid instruction never affects state or outputs.
//
// TESTING
// - Reset: hold i_arst=0 for 2 cycles with random inputs -> every output 0, FSM in RUN.
// - Correct predict: pc=0x1000, taken=1, target=0x2000, pred_taken=1, pred_target=0x2000
//   -> next cycle o_bpu_update=1, o_bpu_taken=1, o_mispredict=0; branch_count=1.
// - Direction mispredict: pc=0x1000, taken=0, pred_taken=1
//   -> o_mispredict=1, o_pc_redirect=0x1004, mispred_count=1, FSM enters SQUASH.
//   - The next 2 valid branches are ignored (no update, no count); the 3rd is evaluated.
// - Target mispredict plus stall: taken=1, target=0x3000, pred_target=0x2000
//   -> o_pc_redirect=0x3000.
//   - Then hold stall for 3 cycles: SQUASH persists, counter holds at 2.
//   - Release stall: RUN after 2 unstalled cycles.
// - Wrap and saturation:
//   - pc=0xFFFF_FFFF_FFFF_FFFC, not-taken mispredict -> redirect=0x0.
//   - COUNT_WIDTH=4 with 20 branches -> branch_count stays 4'hF.
// - Reset mid-SQUASH: mispredict, then i_arst=0 one cycle later
//   -> RUN, counters 0; the next branch is evaluated immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: mispredict detection, fetch redirect, predictor update bus,
// wrong-path squash window and saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_exec,
    input  logic                   i_valid_exec,
    input  logic                   i_branch_instr,
    input  logic                   i_branch_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pc_exec,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target_exec,
    input  logic                   i_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pred_target,
    input  logic [1:0]             i_pred_way,
    output logic                   o_mispredict,
    output logic [ADDR_WIDTH-1:0]  o_pc_redirect,
    output logic                   o_bpu_update,
    output logic                   o_bpu_taken,
    output logic [ADDR_WIDTH-1:0]  o_bpu_pc,
    output logic [ADDR_WIDTH-1:0]  o_bpu_target,
    output logic [1:0]             o_bpu_way,
    output logic [COUNT_WIDTH-1:0] o_branch_count,
    output logic [COUNT_WIDTH-1:0] o_mispred_count
);

    localparam int unsigned SqW = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {StRun, StSquash} state_e;

    state_e                  state_q, state_d;
    logic [SqW-1:0]          sq_cnt_q, sq_cnt_d;
    logic                    mispredict_q, mispredict_d;
    logic [ADDR_WIDTH-1:0]   redirect_q, redirect_d;
    logic                    update_q, update_d;
    logic                    taken_q, taken_d;
    logic [ADDR_WIDTH-1:0]   bpu_pc_q, bpu_pc_d;
    logic [ADDR_WIDTH-1:0]   bpu_target_q, bpu_target_d;
    logic [1:0]              bpu_way_q, bpu_way_d;
    logic [COUNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [COUNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
    logic                    eval, mis;

    assign eval = i_valid_exec & i_branch_instr & ~i_stall_exec & (state_q == StRun);
    assign mis  = eval & ((i_pred_taken != i_branch_taken)
                        | (i_pred_taken & i_branch_taken & (i_pred_target != i_pc_target_exec)));

    always_comb begin
        state_d       = state_q;
        sq_cnt_d      = sq_cnt_q;
        mispredict_d  = mis;
        update_d      = eval;
        redirect_d    = redirect_q;
        taken_d       = taken_q;
        bpu_pc_d      = bpu_pc_q;
        bpu_target_d  = bpu_target_q;
        bpu_way_d     = bpu_way_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (eval) begin
            taken_d      = i_branch_taken;
            bpu_pc_d     = i_pc_exec;
            bpu_target_d = i_pc_target_exec;
            bpu_way_d    = i_pred_way;
            if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + COUNT_WIDTH'(1);
        end

        if (mis) begin
            redirect_d = i_branch_taken ? i_pc_target_exec : i_pc_exec + ADDR_WIDTH'(4);
            if (!(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + COUNT_WIDTH'(1);
        end

        unique case (state_q)
            StRun: begin
                if (mis) begin
                    state_d  = StSquash;
                    sq_cnt_d = SqW'(FLUSH_DEPTH);
                end
            end
            StSquash: begin
                // Leaving as the count hits 0 gives exactly FLUSH_DEPTH ignored cycles.
                if (!i_stall_exec) begin
                    sq_cnt_d = sq_cnt_q - SqW'(1);
                    if (sq_cnt_q <= SqW'(1)) begin
                        state_d  = StRun;
                        sq_cnt_d = '0;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state_q       <= StRun;
            sq_cnt_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            update_q      <= 1'b0;
            taken_q       <= 1'b0;
            bpu_pc_q      <= '0;
            bpu_target_q  <= '0;
            bpu_way_q     <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sq_cnt_q      <= sq_cnt_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            update_q      <= update_d;
            taken_q       <= taken_d;
            bpu_pc_q      <= bpu_pc_d;
            bpu_target_q  <= bpu_target_d;
            bpu_way_q     <= bpu_way_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_mispredict    = mispredict_q;
    assign o_pc_redirect   = redirect_q;
    assign o_bpu_update    = update_q;
    assign o_bpu_taken     = taken_q;
    assign o_bpu_pc        = bpu_pc_q;
    assign o_bpu_target    = bpu_target_q;
    assign o_bpu_way       = bpu_way_q;
    assign o_branch_count  = branch_cnt_q;
    assign o_mispred_count = mispred_cnt_q;

endmodule
